wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 49 ++++
 rtl/wb_stage.sv | 119 +++++++++++
 tb/tb_wb_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared defaults and the grant-source encoding for the writeback stage.
package wb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with power-of-two depth; the read data is the head entry.
module wb_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU (FIFO) and load (holding register) results into one GPR write port.
// Optional WB_FWD_EN adds two combinational forwarding lookups on the write port.
module wb_stage import wb_pkg::*; #(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int ALU_FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr1,
    input  logic [ADDR_W-1:0] fwd_addr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`endif
);

    localparam int CW = $clog2(ALU_FIFO_DEPTH) + 1;
    localparam int PW = ADDR_W + DATA_W;

    logic [CW-1:0]     alu_count;
    logic              alu_full;
    logic              alu_empty;
    logic [PW-1:0]     alu_head;
    logic              alu_push;

    logic              mem_vld;
    logic [ADDR_W-1:0] mem_dest_q;
    logic [DATA_W-1:0] mem_data_q;

    src_e              last_grant;
    logic              grant_alu;
    logic              grant_mem;

    assign alu_ready = (alu_count != CW'(ALU_FIFO_DEPTH));
    assign alu_push  = alu_valid && !alu_full;
    assign mem_ready = !mem_vld;

    wb_fifo #(
        .W     (PW),
        .DEPTH (ALU_FIFO_DEPTH)
    ) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .pop   (grant_alu),
        .din   ({alu_dest, alu_data}),
        .dout  (alu_head),
        .full  (alu_full),
        .empty (alu_empty),
        .count (alu_count)
    );

    // Pending state is registered only, so a fresh result always waits one edge before grant.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!alu_empty && mem_vld) begin
            if (last_grant == SRC_ALU) grant_mem = 1'b1;
            else                       grant_alu = 1'b1;
        end else begin
            grant_alu = !alu_empty;
            grant_mem = mem_vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_vld        <= 1'b0;
            mem_dest_q     <= '0;
            mem_data_q     <= '0;
            last_grant     <= SRC_ALU;
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else begin
            // mem_ready is low while occupied, so a grant and a new load never coincide.
            if (mem_valid && mem_ready) begin
                mem_vld    <= 1'b1;
                mem_dest_q <= mem_dest;
                mem_data_q <= mem_data;
            end else if (grant_mem) begin
                mem_vld <= 1'b0;
            end

            reg_write_en <= grant_alu || grant_mem;
            if (grant_alu) begin
                {reg_write_dest, reg_write_data} <= alu_head;
                last_grant <= SRC_ALU;
            end else if (grant_mem) begin
                reg_write_dest <= mem_dest_q;
                reg_write_data <= mem_data_q;
                last_grant     <= SRC_MEM;
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_hit1  = reg_write_en && (reg_write_dest == fwd_addr1);
    assign fwd_hit2  = reg_write_en && (reg_write_dest == fwd_addr2);
    assign fwd_data1 = reg_write_data;
    assign fwd_data2 = reg_write_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_wb_stage;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] d;
        logic [DW-1:0] v;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_dest, mem_dest;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          reg_write_en;
    logic [AW-1:0] reg_write_dest;
    logic [DW-1:0] reg_write_data;
`ifdef WB_FWD_EN
    logic [AW-1:0] fwd_addr1, fwd_addr2;
    logic          fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
`endif

    int checks = 0;
    int errors = 0;

    ent_t          aq[$];
    ent_t          mq[$];
    bit            m_last_mem;
    logic          m_en;
    logic [AW-1:0] m_dest;
    logic [DW-1:0] m_data;

    wb_stage #(.DATA_W(DW), .ADDR_W(AW), .ALU_FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .mem_valid      (mem_valid),
        .mem_dest       (mem_dest),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data)
`ifdef WB_FWD_EN
        ,
        .fwd_addr1      (fwd_addr1),
        .fwd_addr2      (fwd_addr2),
        .fwd_hit1       (fwd_hit1),
        .fwd_hit2       (fwd_hit2),
        .fwd_data1      (fwd_data1),
        .fwd_data2      (fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        aq.delete();
        mq.delete();
        m_last_mem = 1'b0;
        m_en       = 1'b0;
        m_dest     = '0;
        m_data     = '0;
    endtask

    task automatic test_reset();
        idle();
        alu_dest = '0; alu_data = '0; mem_dest = '0; mem_data = '0;
        rst = 1'b1;
        #3;
        checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b want=0", reg_write_en); end
        checks++; if (reg_write_dest !== '0) begin errors++; $display("FAIL reset_dest got=%0d want=0", reg_write_dest); end
        checks++; if (reg_write_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0000", reg_write_data); end
        apply_reset();
        tick();
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got=%b want=1", alu_ready); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got=%b want=1", mem_ready); end
    endtask

    task automatic test_single_alu();
        apply_reset();
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
        tick();
        idle();
        checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL single_early got=%b want=0", reg_write_en); end
        tick();
        checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd3 || reg_write_data !== 16'h1234) begin
            errors++; $display("FAIL single_write got=%b/%0d/%h want=1/3/1234", reg_write_en, reg_write_dest, reg_write_data);
        end
        tick();
        checks++;
        if (reg_write_en !== 1'b0 || reg_write_dest !== 3'd3 || reg_write_data !== 16'h1234) begin
            errors++; $display("FAIL single_after got=%b/%0d/%h want=0/3/1234", reg_write_en, reg_write_dest, reg_write_data);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'hAAAA;
        mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'h5555;
        tick();
        idle();
        tick();
        checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd2 || reg_write_data !== 16'h5555) begin
            errors++; $display("FAIL tie_first got=%b/%0d/%h want=1/2/5555", reg_write_en, reg_write_dest, reg_write_data);
        end
        tick();
        checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd1 || reg_write_data !== 16'hAAAA) begin
            errors++; $display("FAIL tie_second got=%b/%0d/%h want=1/1/aaaa", reg_write_en, reg_write_dest, reg_write_data);
        end
        tick();
        checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL tie_idle got=%b want=0", reg_write_en); end
    endtask

    task automatic test_alu_burst();
        apply_reset();
        alu_valid = 1'b1; alu_dest = 3'd6;
        for (int i = 1; i <= 3; i++) begin
            alu_data = DW'(i);
            tick();
            checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL burst_ready i=%0d got=%b want=1", i, alu_ready); end
            if (i > 1) begin
                checks++;
                if (reg_write_en !== 1'b1 || reg_write_data !== DW'(i - 1)) begin
                    errors++; $display("FAIL burst_data i=%0d got=%b/%h want=1/%h", i, reg_write_en, reg_write_data, i - 1);
                end
            end
        end
        idle();
        tick();
        checks++;
        if (reg_write_en !== 1'b1 || reg_write_data !== 16'd3) begin
            errors++; $display("FAIL burst_last got=%b/%h want=1/0003", reg_write_en, reg_write_data);
        end
        tick();
        checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL burst_idle got=%b want=0", reg_write_en); end
    endtask

    task automatic test_mem_stream();
        int nxt = 0;
        int acc = 0;
        int wr  = 0;
        bit took;
        apply_reset();
        mem_valid = 1'b1; mem_dest = '0; mem_data = 16'h0100;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (mem_ready !== ((c % 2) == 0)) begin
                errors++; $display("FAIL mem_ready c=%0d got=%b want=%b", c, mem_ready, (c % 2) == 0);
            end
            if (reg_write_en === 1'b1) begin
                checks++;
                if (reg_write_data !== DW'(16'h0100 + wr)) begin
                    errors++; $display("FAIL mem_order got=%h want=%h", reg_write_data, 16'h0100 + wr);
                end
                wr++;
            end
            took = mem_ready;
            tick();
            if (took) begin
                acc++; nxt++;
                mem_dest = AW'(nxt);
                mem_data = DW'(16'h0100 + nxt);
            end
        end
        idle();
        for (int c = 0; c < 3; c++) begin
            if (reg_write_en === 1'b1) begin
                checks++;
                if (reg_write_data !== DW'(16'h0100 + wr)) begin
                    errors++; $display("FAIL mem_drain got=%h want=%h", reg_write_data, 16'h0100 + wr);
                end
                wr++;
            end
            tick();
        end
        checks++; if (wr != acc) begin errors++; $display("FAIL mem_count got=%0d want=%0d", wr, acc); end
    endtask

    task automatic test_random();
        bit   a_rdy, m_rdy, use_mem;
        ent_t e;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (reg_write_en !== m_en || reg_write_dest !== m_dest || reg_write_data !== m_data) begin
                errors++; $display("FAIL rand_out c=%0d got=%b/%0d/%h want=%b/%0d/%h", c,
                                   reg_write_en, reg_write_dest, reg_write_data, m_en, m_dest, m_data);
            end
            a_rdy = (aq.size() != DEPTH);
            m_rdy = (mq.size() == 0);
            checks++;
            if (alu_ready !== a_rdy || mem_ready !== m_rdy) begin
                errors++; $display("FAIL rand_ready c=%0d got=%b%b want=%b%b", c, alu_ready, mem_ready, a_rdy, m_rdy);
            end
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_dest  = AW'($urandom());
            alu_data  = DW'($urandom());
            mem_valid = ($urandom_range(0, 2) == 0);
            mem_dest  = AW'($urandom());
            mem_data  = DW'($urandom());
            // Round-robin: on a tie the source not served last wins.
            if (aq.size() > 0 || mq.size() > 0) begin
                use_mem = (aq.size() > 0 && mq.size() > 0) ? !m_last_mem : (mq.size() > 0);
                e = use_mem ? mq.pop_front() : aq.pop_front();
                m_en = 1'b1; m_dest = e.d; m_data = e.v; m_last_mem = use_mem;
            end else begin
                m_en = 1'b0;
            end
            if (alu_valid && a_rdy) aq.push_back('{d: alu_dest, v: alu_data});
            if (mem_valid && m_rdy) mq.push_back('{d: mem_dest, v: mem_data});
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        bit got_full = 1'b0;
        apply_reset();
        alu_valid = 1'b1; mem_valid = 1'b1;
        for (int c = 0; c < 12 && !got_full; c++) begin
            alu_dest = AW'($urandom()); alu_data = DW'($urandom());
            mem_dest = AW'($urandom()); mem_data = DW'($urandom());
            tick();
            got_full = (alu_ready === 1'b0);
        end
        checks++; if (!got_full) begin errors++; $display("FAIL midrst_full got=alu_ready_high want=alu_ready_low"); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL midrst_en got=%b want=0", reg_write_en); end
        checks++;
        if (reg_write_dest !== '0 || reg_write_data !== '0) begin
            errors++; $display("FAIL midrst_payload got=%0d/%h want=0/0000", reg_write_dest, reg_write_data);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL midrst_ghost c=%0d got=%b want=0", c, reg_write_en); end
            checks++;
            if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
                errors++; $display("FAIL midrst_ready c=%0d got=%b%b want=11", c, alu_ready, mem_ready);
            end
        end
    endtask

`ifdef WB_FWD_EN
    task automatic test_fwd();
        apply_reset();
        fwd_addr1 = 3'd5; fwd_addr2 = 3'd4;
        alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h00FF;
        tick();
        idle();
        checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("FAIL fwd_early got=%b want=0", fwd_hit1); end
        tick();
        checks++;
        if (fwd_hit1 !== 1'b1 || fwd_data1 !== 16'h00FF) begin
            errors++; $display("FAIL fwd_hit1 got=%b/%h want=1/00ff", fwd_hit1, fwd_data1);
        end
        checks++; if (fwd_hit2 !== 1'b0) begin errors++; $display("FAIL fwd_hit2 got=%b want=0", fwd_hit2); end
        fwd_addr2 = 3'd5;
        #1;
        checks++;
        if (fwd_hit2 !== 1'b1 || fwd_data2 !== 16'h00FF) begin
            errors++; $display("FAIL fwd_hit2_comb got=%b/%h want=1/00ff", fwd_hit2, fwd_data2);
        end
    endtask
`endif

    initial begin
`ifdef WB_FWD_EN
        fwd_addr1 = '0; fwd_addr2 = '0;
`endif
        test_reset();
        test_single_alu();
        test_tie();
        test_alu_burst();
        test_mem_stream();
        test_random();
        test_reset_midflight();
`ifdef WB_FWD_EN
        test_fwd();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
